muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide execution unit, downstream of register_file.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: widths, RV32M funct3 codes and the mul/div FSM encoding.
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with one-cycle write-back pulse.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  MD_IDLE | waiting for start; accepts a new op
//  MD_CALC | one shift-add / restoring-subtract step per cycle, 32 steps
//  MD_DONE | result/rd_out valid, done and regwrite pulse for one cycle
module muldiv_unit
   import rv32_pkg::*;
#(
   parameter int XLEN       = rv32_pkg::XLEN,
   parameter int REG_ADDR_W = rv32_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       op_a,
   input  logic [XLEN-1:0]       op_b,
   input  logic [REG_ADDR_W-1:0] rd_in,
   output logic                  busy,
   output logic                  done,
   output logic [XLEN-1:0]       result,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  regwrite
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   md_state_e               state_q, state_d;
   logic [2:0]              f3_q, f3_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic                    neg_q, neg_d;
   logic [XLEN-1:0]         opnd_q, opnd_d;
   logic [2*XLEN-1:0]       acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [XLEN-1:0]         result_q, result_d;

   logic                    sgn_a_en, sgn_b_en, sign_a, sign_b;
   logic [XLEN-1:0]         mag_a, mag_b;
   logic                    in_div, div_zero, div_ovf;
   logic [XLEN:0]           mul_sum, div_trial;
   logic [2*XLEN-1:0]       step, prod_s;
   logic [XLEN-1:0]         div_raw, final_res;

   // Operand magnitudes and result sign for the op presented on the inputs.
   always_comb begin
      sgn_a_en = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
              || (funct3 == F3_DIV) || (funct3 == F3_REM);
      sgn_b_en = (funct3 == F3_MUL) || (funct3 == F3_MULH)
              || (funct3 == F3_DIV) || (funct3 == F3_REM);
      sign_a   = sgn_a_en & op_a[XLEN-1];
      sign_b   = sgn_b_en & op_b[XLEN-1];
      mag_a    = sign_a ? -op_a : op_a;
      mag_b    = sign_b ? -op_b : op_b;
      in_div   = funct3[2];
      div_zero = in_div && (op_b == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM))
              && (op_a == INT_MIN) && (op_b == ALL_ONES);
   end

   // One iteration step plus the sign-corrected result it would produce if it were the last.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
      if (f3_q[2]) begin
         step = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         step = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod_s  = neg_q ? -step : step;
      div_raw = f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
      if (f3_q[2]) begin
         final_res = neg_q ? -div_raw : div_raw;
      end else if (f3_q == F3_MUL) begin
         final_res = prod_s[XLEN-1:0];
      end else begin
         final_res = prod_s[2*XLEN-1:XLEN];
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         MD_IDLE: begin
            if (start) begin
               f3_d  = funct3;
               rd_d  = rd_in;
               cnt_d = '0;
               if (in_div) begin
                  neg_d  = funct3[1] ? sign_a : (sign_a ^ sign_b);
                  opnd_d = mag_b;
               end else begin
                  neg_d  = sign_a ^ sign_b;
                  opnd_d = mag_a;
               end
               acc_d = {{XLEN{1'b0}}, in_div ? mag_a : mag_b};
               if (div_zero) begin
                  result_d = funct3[1] ? op_a : ALL_ONES;
                  state_d  = MD_DONE;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : INT_MIN;
                  state_d  = MD_DONE;
               end else begin
                  state_d  = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               result_d = final_res;
               state_d  = MD_DONE;
            end
         end
         MD_DONE: begin
            state_d = MD_IDLE;
         end
         default: begin
            state_d = MD_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any op in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= MD_IDLE;
         f3_q     <= '0;
         rd_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy     = (state_q != MD_IDLE);
   assign done     = (state_q == MD_DONE);
   assign result   = result_q;
   assign rd_out   = rd_q;
   assign regwrite = done && (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven check of muldiv_unit plus multi-cycle corner sequences.
module tb_muldiv_unit;
   import rv32_pkg::*;

   logic        clk, rst, start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done, regwrite;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int total = 0;
   int bad   = 0;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result),
      .rd_out(rd_out), .regwrite(regwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      logic        special;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Present an op for one edge, then wait (bounded) for done; lat = edges after accept.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output int lat,
                         output logic rw, output logic [4:0] rdo);
      funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; res = '0; rw = 1'b0; rdo = '0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            lat = k; res = result; rw = regwrite; rdo = rd_out;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] res;
   int          lat;
   logic        rw;
   logic [4:0]  rdo;
   int          seen;

   initial begin
      vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b0};
      vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0};
      vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0};
      vecs[6]  = '{F3_DIVU,   32'd100,      32'd7,         5'd11, 32'd14,        1'b0};
      vecs[7]  = '{F3_REMU,   32'd100,      32'd7,         5'd12, 32'd2,         1'b0};
      vecs[8]  = '{F3_DIV,    32'd1234,     32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{F3_REMU,   32'd5,        32'd0,         5'd14, 32'd5,         1'b1};
      vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1};
      vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1'b1};
      vecs[12] = '{F3_MUL,    32'h1234_5678, 32'd9,         5'd0,  32'hA3D7_0A38, 1'b0};
      vecs[13] = '{F3_DIV,    32'd7,        32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 1'b0};
      vecs[14] = '{F3_REM,    32'd7,        32'hFFFF_FFFE, 5'd18, 32'd1,         1'b0};

      rst = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, res, lat, rw, rdo);
         chk($sformatf("v%0d_result", i), res, vecs[i].exp);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].special ? 32'd0 : 32'd32);
         chk($sformatf("v%0d_rd_out", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
         chk($sformatf("v%0d_regwrite", i), {31'd0, rw}, {31'd0, (vecs[i].rd != 5'd0)});
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
         chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      end

      // start while busy is ignored; held start in DONE is also ignored
      funct3 = F3_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int k = 5; k < 40; k++) begin
         if (done) begin
            lat = k; res = result; rdo = rd_out;
            break;
         end
         @(posedge clk); #1;
      end
      chk("busy_ign_latency", lat, 32'd32);
      chk("busy_ign_result", res, 32'hFFFF_FFEB);
      chk("busy_ign_rd_out", {27'd0, rdo}, 32'd5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_ign_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      // reset at CALC cycle 10 abandons the op
      funct3 = F3_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      @(negedge clk); rst = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("mid_rst_no_done", seen, 32'd0);
      run_op(F3_DIVU, 32'd100, 32'd7, 5'd4, res, lat, rw, rdo);
      chk("post_rst_result", res, 32'd14);
      chk("post_rst_latency", lat, 32'd32);
      chk("post_rst_regwrite", {31'd0, rw}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
